// File: rtl/serdesphy_power_sequencer.sv
// SerDes PHY power-up and lock-recovery sequencer, 24 MHz reference domain.
// Define SERDESPHY_SEQ_AUTO_RETRY_EN to let FAULT retry up to MAX_RETRY times.
module serdesphy_power_sequencer #(
    parameter int PLL_RST_CYCLES   = 48,
    parameter int PLL_LOCK_TIMEOUT = 2400,
    parameter int CDR_RST_CYCLES   = 24,
    parameter int CDR_LOCK_TIMEOUT = 4800,
    parameter int LOCK_FILT        = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk_ref_24m,
    input  logic       rst_in,
    input  logic       phy_en_req,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    output logic       phy_en,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       seq_ready,
    output logic       seq_fault,
    output logic [2:0] seq_state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PLL_RST  = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_CDR_RST  = 3'd3,
        ST_CDR_WAIT = 3'd4,
        ST_READY    = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif
    localparam logic [1:0] RETRY_LIMIT = AUTO_RETRY ? 2'(MAX_RETRY) : 2'd0;

    localparam int MAX_RST  = (PLL_RST_CYCLES > CDR_RST_CYCLES) ? PLL_RST_CYCLES : CDR_RST_CYCLES;
    localparam int MAX_TO   = (PLL_LOCK_TIMEOUT > CDR_LOCK_TIMEOUT) ? PLL_LOCK_TIMEOUT : CDR_LOCK_TIMEOUT;
    localparam int MAX_T    = (MAX_RST > MAX_TO) ? MAX_RST : MAX_TO;
    localparam int CNT_W    = $clog2(MAX_T) + 1;
    localparam int FILT_W   = $clog2(LOCK_FILT + 1);

    // The step counter reads 0 in the first cycle of a state, so an N-cycle
    // window closes on the edge where the counter shows N-1.
    localparam logic [CNT_W-1:0]  PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PLL_WAIT_LAST = CNT_W'(PLL_LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CDR_RST_LAST  = CNT_W'(CDR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CDR_WAIT_LAST = CNT_W'(CDR_LOCK_TIMEOUT - 1);
    localparam logic [FILT_W-1:0] FILT_QUAL     = FILT_W'(LOCK_FILT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FILT_W-1:0] pll_filt_q, pll_filt_d;
    logic [FILT_W-1:0] cdr_filt_q, cdr_filt_d;
    logic [1:0]        retry_cnt_q, retry_cnt_d;
    logic              pll_qual, cdr_qual;

    always_ff @(posedge clk_ref_24m or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            pll_filt_q  <= '0;
            cdr_filt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_filt_q  <= pll_filt_d;
            cdr_filt_q  <= cdr_filt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign pll_qual = (pll_filt_q == FILT_QUAL);
    assign cdr_qual = (cdr_filt_q == FILT_QUAL);

    // Lock filters run in every state and are never cleared by a state change.
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        pll_filt_d = '0;
        cdr_filt_d = '0;
        if (pll_lock) begin
            pll_filt_d = pll_qual ? pll_filt_q : pll_filt_q + 1'b1;
        end
        if (cdr_lock) begin
            cdr_filt_d = cdr_qual ? cdr_filt_q : cdr_filt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        if (!phy_en_req) begin
            state_d     = ST_OFF;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                ST_OFF:      state_d = ST_PLL_RST;
                ST_PLL_RST:  if (cnt_q == PLL_RST_LAST) state_d = ST_PLL_WAIT;
                ST_PLL_WAIT: begin
                    if (pll_qual)                    state_d = ST_CDR_RST;
                    else if (cnt_q == PLL_WAIT_LAST) state_d = ST_FAULT;
                end
                ST_CDR_RST: begin
                    if (!pll_lock)                  state_d = ST_PLL_RST;
                    else if (cnt_q == CDR_RST_LAST) state_d = ST_CDR_WAIT;
                end
                ST_CDR_WAIT: begin
                    if (!pll_lock)                   state_d = ST_PLL_RST;
                    else if (cdr_qual)               state_d = ST_READY;
                    else if (cnt_q == CDR_WAIT_LAST) state_d = ST_FAULT;
                end
                ST_READY: begin
                    if (!pll_lock)      state_d = ST_PLL_RST;
                    else if (!cdr_lock) state_d = ST_CDR_RST;
                end
                ST_FAULT: begin
                    if (AUTO_RETRY && cnt_q == PLL_RST_LAST && retry_cnt_q < RETRY_LIMIT) begin
                        state_d     = ST_PLL_RST;
                        retry_cnt_d = retry_cnt_q + 2'd1;
                    end
                end
                default:     state_d = ST_OFF;
            endcase
            if (state_d == ST_READY) retry_cnt_d = '0;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        phy_en    = 1'b0;
        pll_rst   = 1'b0;
        cdr_rst   = 1'b0;
        tx_en     = 1'b0;
        rx_en     = 1'b0;
        seq_ready = 1'b0;
        seq_fault = 1'b0;
        case (state_q)
            ST_OFF: begin
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
            ST_PLL_RST: begin
                phy_en  = 1'b1;
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
            ST_PLL_WAIT: begin
                phy_en  = 1'b1;
                cdr_rst = 1'b1;
            end
            ST_CDR_RST: begin
                phy_en  = 1'b1;
                tx_en   = 1'b1;
                cdr_rst = 1'b1;
            end
            ST_CDR_WAIT: begin
                phy_en = 1'b1;
                tx_en  = 1'b1;
            end
            ST_READY: begin
                phy_en    = 1'b1;
                tx_en     = 1'b1;
                rx_en     = 1'b1;
                seq_ready = 1'b1;
            end
            ST_FAULT: begin
                pll_rst   = 1'b1;
                cdr_rst   = 1'b1;
                seq_fault = 1'b1;
            end
            default: begin
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
        endcase
    end

    assign seq_state = state_q;
    assign retry_cnt = AUTO_RETRY ? retry_cnt_q : 2'b00;

endmodule

// File: tb/tb_serdesphy_power_sequencer.sv
// Bench for serdesphy_power_sequencer: directed scenarios plus randomized lock
// activity, all compared against a cycle-level reference model of the sequencing rules.
module tb_serdesphy_power_sequencer;

    localparam int PLL_RST_CYCLES   = 4;
    localparam int PLL_LOCK_TIMEOUT = 20;
    localparam int CDR_RST_CYCLES   = 3;
    localparam int CDR_LOCK_TIMEOUT = 30;
    localparam int LOCK_FILT        = 2;
    localparam int MAX_RETRY        = 2;

    localparam int S_OFF = 0, S_PLL_RST = 1, S_PLL_WAIT = 2, S_CDR_RST = 3;
    localparam int S_CDR_WAIT = 4, S_READY = 5, S_FAULT = 6;

    // {phy_en, pll_rst, cdr_rst, tx_en, rx_en, seq_ready, seq_fault, seq_state, retry_cnt}
    localparam logic [11:0] RESET_VEC = 12'b0110000_000_00;

    logic       clk_ref_24m;
    logic       rst_in;
    logic       phy_en_req;
    logic       pll_lock;
    logic       cdr_lock;
    logic       phy_en;
    logic       pll_rst;
    logic       cdr_rst;
    logic       tx_en;
    logic       rx_en;
    logic       seq_ready;
    logic       seq_fault;
    logic [2:0] seq_state;
    logic [1:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, cycles already spent in it, lock run lengths.
    int m_state, m_in_state, m_pll_run, m_cdr_run, m_retry;

    serdesphy_power_sequencer #(
        .PLL_RST_CYCLES  (PLL_RST_CYCLES),
        .PLL_LOCK_TIMEOUT(PLL_LOCK_TIMEOUT),
        .CDR_RST_CYCLES  (CDR_RST_CYCLES),
        .CDR_LOCK_TIMEOUT(CDR_LOCK_TIMEOUT),
        .LOCK_FILT       (LOCK_FILT),
        .MAX_RETRY       (MAX_RETRY)
    ) dut (
        .clk_ref_24m(clk_ref_24m),
        .rst_in     (rst_in),
        .phy_en_req (phy_en_req),
        .pll_lock   (pll_lock),
        .cdr_lock   (cdr_lock),
        .phy_en     (phy_en),
        .pll_rst    (pll_rst),
        .cdr_rst    (cdr_rst),
        .tx_en      (tx_en),
        .rx_en      (rx_en),
        .seq_ready  (seq_ready),
        .seq_fault  (seq_fault),
        .seq_state  (seq_state),
        .retry_cnt  (retry_cnt)
    );

    initial clk_ref_24m = 1'b0;
    always #20 clk_ref_24m = ~clk_ref_24m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit=1000000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] dut_vec();
        return {phy_en, pll_rst, cdr_rst, tx_en, rx_en, seq_ready, seq_fault, seq_state, retry_cnt};
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [6:0] ctl;
        ctl[6] = (m_state inside {[S_PLL_RST:S_READY]});
        ctl[5] = (m_state inside {S_OFF, S_PLL_RST, S_FAULT});
        ctl[4] = (m_state inside {[S_OFF:S_CDR_RST], S_FAULT});
        ctl[3] = (m_state inside {[S_CDR_RST:S_READY]});
        ctl[2] = (m_state == S_READY);
        ctl[1] = (m_state == S_READY);
        ctl[0] = (m_state == S_FAULT);
        return {ctl, 3'(m_state), 2'(m_retry)};
    endfunction

    task automatic model_reset();
        m_state    = S_OFF;
        m_in_state = 0;
        m_pll_run  = 0;
        m_cdr_run  = 0;
        m_retry    = 0;
    endtask

    task automatic model_step(input logic req, input logic pl, input logic cl);
        int  nxt;
        int  spent;
        bit  pll_ok;
        bit  cdr_ok;
        pll_ok = (m_pll_run >= LOCK_FILT);
        cdr_ok = (m_cdr_run >= LOCK_FILT);
        spent  = m_in_state + 1;
        nxt    = m_state;
        if (!req) begin
            nxt     = S_OFF;
            m_retry = 0;
        end else begin
            case (m_state)
                S_OFF:      nxt = S_PLL_RST;
                S_PLL_RST:  if (spent == PLL_RST_CYCLES) nxt = S_PLL_WAIT;
                S_PLL_WAIT: begin
                    if (pll_ok) nxt = S_CDR_RST;
                    else if (spent == PLL_LOCK_TIMEOUT) nxt = S_FAULT;
                end
                S_CDR_RST: begin
                    if (!pl) nxt = S_PLL_RST;
                    else if (spent == CDR_RST_CYCLES) nxt = S_CDR_WAIT;
                end
                S_CDR_WAIT: begin
                    if (!pl) nxt = S_PLL_RST;
                    else if (cdr_ok) nxt = S_READY;
                    else if (spent == CDR_LOCK_TIMEOUT) nxt = S_FAULT;
                end
                S_READY: begin
                    if (!pl) nxt = S_PLL_RST;
                    else if (!cl) nxt = S_CDR_RST;
                end
                S_FAULT: begin
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
                    if (spent == PLL_RST_CYCLES && m_retry < MAX_RETRY) begin
                        nxt     = S_PLL_RST;
                        m_retry = m_retry + 1;
                    end
`endif
                end
                default: nxt = S_OFF;
            endcase
            if (nxt == S_READY) m_retry = 0;
        end
        m_in_state = (nxt != m_state) ? 0 : m_in_state + 1;
        m_state    = nxt;
        m_pll_run  = pl ? m_pll_run + 1 : 0;
        m_cdr_run  = cl ? m_cdr_run + 1 : 0;
    endtask

    task automatic tick(input logic req, input logic pl, input logic cl);
        phy_en_req = req;
        pll_lock   = pl;
        cdr_lock   = cl;
        @(posedge clk_ref_24m);
        model_step(req, pl, cl);
        #1;
    endtask

    task automatic run_until(input int target, input logic pl, input logic cl,
                             input int budget, output bit reached);
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            tick(1'b1, pl, cl);
            if (seq_state == 3'(target)) reached = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_in     = 1'b1;
        phy_en_req = 1'b0;
        pll_lock   = 1'b0;
        cdr_lock   = 1'b0;
        repeat (3) @(posedge clk_ref_24m);
        #1;
        model_reset();
        n_tests++;
        if (dut_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", dut_vec(), RESET_VEC);
        end
        phy_en_req = 1'b1;
        @(negedge clk_ref_24m);
        rst_in = 1'b0;
    endtask

    task automatic test_bring_up();
        int         pll_rst_hi;
        int         seen[$];
        int         want[5] = '{1, 2, 3, 4, 5};
        logic [2:0] prev;
        bit         done;
        bit         seq_ok;
        pll_rst_hi = 0;
        prev       = seq_state;
        done       = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            tick(1'b1, 1'(cyc >= 6), 1'(m_state == S_CDR_WAIT || m_state == S_READY));
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bring_up cyc %0d: got %b want %b", cyc, dut_vec(), exp_vec());
            end
            if (phy_en === 1'b1 && pll_rst === 1'b1) pll_rst_hi++;
            if (seq_state !== prev) begin
                seen.push_back(int'(seq_state));
                prev = seq_state;
            end
            if (seq_state == 3'(S_READY)) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL bring_up_timeout: state %0d, want %0d within 200 cycles", seq_state, S_READY);
        end
        n_tests++;
        if (pll_rst_hi != PLL_RST_CYCLES) begin
            n_fail++;
            $display("FAIL bring_up_pll_rst_width: got %0d cycles want %0d", pll_rst_hi, PLL_RST_CYCLES);
        end
        seq_ok = (seen.size() == 5);
        for (int i = 0; i < 5 && seq_ok; i++) if (seen[i] != want[i]) seq_ok = 1'b0;
        n_tests++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL bring_up_state_order: got %p want %p", seen, want);
        end
        n_tests++;
        if (seq_ready !== 1'b1 || rx_en !== 1'b1) begin
            n_fail++;
            $display("FAIL bring_up_ready: seq_ready=%b rx_en=%b want 1 1", seq_ready, rx_en);
        end
    endtask

    task automatic test_lock_glitch();
        bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit ok;
        int hit;
        tick(1'b0, 1'b0, 1'b0);
        run_until(S_PLL_WAIT, 1'b0, 1'b0, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL glitch_reach_pll_wait: state %0d want %0d", seq_state, S_PLL_WAIT);
        end
        hit = -1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, pat[i], 1'b0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch step %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (hit < 0 && seq_state == 3'(S_CDR_RST)) hit = i;
        end
        n_tests++;
        if (hit != 2 + LOCK_FILT) begin
            n_fail++;
            $display("FAIL glitch_qualify_step: got %0d want %0d", hit, 2 + LOCK_FILT);
        end
    endtask

    task automatic test_pll_timeout();
        bit ok;
        int in_wait;
        tick(1'b0, 1'b0, 1'b0);
        run_until(S_PLL_WAIT, 1'b0, 1'b0, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_reach_pll_wait: state %0d want %0d", seq_state, S_PLL_WAIT);
        end
        in_wait = 1;
        for (int i = 0; i < 60 && seq_state == 3'(S_PLL_WAIT); i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (seq_state == 3'(S_PLL_WAIT)) in_wait++;
        end
        n_tests++;
        if (in_wait != PLL_LOCK_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_wait_cycles: got %0d want %0d", in_wait, PLL_LOCK_TIMEOUT);
        end
        n_tests++;
        if (seq_state !== 3'(S_FAULT) || seq_fault !== 1'b1 || phy_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: state=%0d fault=%b phy_en=%b want 6 1 0", seq_state, seq_fault, phy_en);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_hold cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
`ifndef SERDESPHY_SEQ_AUTO_RETRY_EN
        n_tests++;
        if (seq_state !== 3'(S_FAULT) || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_sticky: state=%0d retry=%0d want 6 0", seq_state, retry_cnt);
        end
`endif
    endtask

    task automatic test_ready_loss();
        bit ok;
        tick(1'b0, 1'b1, 1'b1);
        run_until(S_READY, 1'b1, 1'b1, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loss_reach_ready: state %0d want %0d", seq_state, S_READY);
        end
        tick(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dut_vec() !== exp_vec() || seq_state !== 3'(S_CDR_RST) || rx_en !== 1'b0 || tx_en !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_cdr: got %b want %b (state 3, rx_en 0, tx_en 1)", dut_vec(), exp_vec());
        end
        run_until(S_READY, 1'b1, 1'b1, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loss_recover_ready: state %0d want %0d", seq_state, S_READY);
        end
        tick(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (dut_vec() !== exp_vec() || seq_state !== 3'(S_PLL_RST)) begin
            n_fail++;
            $display("FAIL loss_pll: got %b want %b (state 1)", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_abort();
        bit ok;
        tick(1'b0, 1'b1, 1'b0);
        run_until(S_CDR_WAIT, 1'b1, 1'b0, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_reach_cdr_wait: state %0d want %0d", seq_state, S_CDR_WAIT);
        end
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dut_vec() !== exp_vec() || seq_state !== 3'(S_OFF) || phy_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_req_low: got %b want %b (state 0)", dut_vec(), exp_vec());
        end
        run_until(S_PLL_WAIT, 1'b0, 1'b0, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_reach_pll_wait: state %0d want %0d", seq_state, S_PLL_WAIT);
        end
        #5 rst_in = 1'b1;
        #2;
        model_reset();
        n_tests++;
        if (dut_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL abort_async_reset: got %b want %b", dut_vec(), RESET_VEC);
        end
        @(negedge clk_ref_24m);
        rst_in = 1'b0;
    endtask

`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
    task automatic test_retry();
        int         seen[$];
        logic [1:0] prev;
        bit         ok;
        bit         got_one;
        tick(1'b0, 1'b0, 1'b0);
        prev = retry_cnt;
        for (int i = 0; i < 150; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL retry cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (retry_cnt !== prev) begin
                seen.push_back(int'(retry_cnt));
                prev = retry_cnt;
            end
        end
        n_tests++;
        if (seen.size() != 2 || seen[0] != 1 || seen[1] != 2) begin
            n_fail++;
            $display("FAIL retry_sequence: got %p want '{1, 2}", seen);
        end
        n_tests++;
        if (seq_state !== 3'(S_FAULT) || retry_cnt !== 2'(MAX_RETRY)) begin
            n_fail++;
            $display("FAIL retry_sticky: state=%0d retry=%0d want 6 %0d", seq_state, retry_cnt, MAX_RETRY);
        end
        tick(1'b0, 1'b0, 1'b0);
        got_one = 1'b0;
        for (int i = 0; i < 100 && !got_one; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (retry_cnt == 2'd1) got_one = 1'b1;
        end
        n_tests++;
        if (!got_one) begin
            n_fail++;
            $display("FAIL retry_first_again: retry=%0d want 1 within 100 cycles", retry_cnt);
        end
        run_until(S_READY, 1'b1, 1'b1, 100, ok);
        n_tests++;
        if (!ok || retry_cnt !== 2'd0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL retry_clear_in_ready: got %b want %b (retry 0)", dut_vec(), exp_vec());
        end
    endtask
`endif

    task automatic test_random();
        logic req, pl, cl;
        int   pll_rate[3] = '{10, 3, 40};
        int   cdr_rate[3] = '{8, 3, 25};
        int   ph;
        pl = 1'b0;
        cl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            ph = i / 500;
            if ($urandom_range(pll_rate[ph] - 1, 0) == 0) pl = ~pl;
            if ($urandom_range(cdr_rate[ph] - 1, 0) == 0) cl = ~cl;
            req = 1'($urandom_range(199, 0) != 0);
            tick(req, pl, cl);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b (req=%b pl=%b cl=%b)",
                         i, dut_vec(), exp_vec(), req, pl, cl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_lock_glitch();
        test_pll_timeout();
        test_ready_loss();
        test_abort();
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
        test_retry();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdesphy_power_sequencer.md
Name: serdesphy_power_sequencer

Overview:
Power-up and recovery sequencer for the SerDes PHY, running in the 24 MHz reference domain. It drives the PHY enable, PLL reset, CDR reset and TX/RX enables in a fixed order. It gates each step on PLL and CDR lock qualification with timeouts, and recovers from lock loss. Its outputs feed the PHY reset synchronizer and the analog PLL/CDR controls.

Parameters:
PLL_RST_CYCLES, 48, cycles pll_rst is held in the PLL_RST state (2 us).
PLL_LOCK_TIMEOUT, 2400, maximum cycles in PLL_WAIT before a fault (100 us).
CDR_RST_CYCLES, 24, cycles cdr_rst is held in the CDR_RST state.
CDR_LOCK_TIMEOUT, 4800, maximum cycles in CDR_WAIT before a fault.
LOCK_FILT, 8, consecutive high cycles required to qualify a lock input.
MAX_RETRY, 3, automatic retries before a sticky fault (used only with the optional feature).

Ports:
clk_ref_24m  input  1  24 MHz reference clock; the only clock.
rst_in  input  1  asynchronous, active-high reset.
phy_en_req  input  1  software PHY enable request; level-sensitive.
pll_lock  input  1  PLL lock, already synchronized to clk_ref_24m.
cdr_lock  input  1  CDR lock, already synchronized to clk_ref_24m.
phy_en  output  1  PHY enable.
pll_rst  output  1  PLL reset, active-high.
cdr_rst  output  1  CDR reset, active-high.
tx_en  output  1  TX datapath enable.
rx_en  output  1  RX datapath enable.
seq_ready  output  1  link fully sequenced.
seq_fault  output  1  lock timeout fault.
seq_state  output  3  current state encoding.
retry_cnt  output  2  retries consumed.

Behaviour:
- Clock and reset: one clock, clk_ref_24m. Reset rst_in is asynchronous and active-high.
- On reset: state=OFF, all counters 0. Outputs: pll_rst=1, cdr_rst=1; phy_en, tx_en, rx_en, seq_ready, seq_fault, retry_cnt all 0.
- Output decode: outputs are Moore outputs decoded from the registered state only. They change on the same edge as the state.
- State encodings and outputs:
  - OFF=0: pll_rst=1, cdr_rst=1, all enables 0.
  - PLL_RST=1: phy_en=1, pll_rst=1, cdr_rst=1.
  - PLL_WAIT=2: phy_en=1, pll_rst=0, cdr_rst=1.
  - CDR_RST=3: phy_en=1, tx_en=1, cdr_rst=1.
  - CDR_WAIT=4: phy_en=1, tx_en=1, cdr_rst=0.
  - READY=5: phy_en=1, tx_en=1, rx_en=1, seq_ready=1.
  - FAULT=6: pll_rst=1, cdr_rst=1, phy_en=0, seq_fault=1.
- Shared step counter: cleared on every state change, saturating. Width is clog2 of the largest timing parameter, plus 1.
- Lock filters: one per lock input. Counts consecutive high cycles and clears on any low cycle. "Qualified" means the count has reached LOCK_FILT.
- Transitions (phy_en_req low has highest priority in every state: go to OFF next edge, clear retry_cnt):
  - OFF -> PLL_RST when phy_en_req=1.
  - PLL_RST -> PLL_WAIT after exactly PLL_RST_CYCLES cycles in PLL_RST.
  - PLL_WAIT -> CDR_RST when pll_lock is qualified.
  - PLL_WAIT -> FAULT when the counter reaches PLL_LOCK_TIMEOUT.
  - If qualification and timeout land on the same cycle, qualification wins.
  - CDR_RST -> CDR_WAIT after exactly CDR_RST_CYCLES cycles. A pll_lock low in CDR_RST -> PLL_RST.
  - CDR_WAIT -> READY when cdr_lock is qualified.
  - CDR_WAIT -> FAULT at CDR_LOCK_TIMEOUT.
  - CDR_WAIT: pll_lock low -> PLL_RST, which takes precedence over the timeout.
  - READY: pll_lock low for one cycle -> PLL_RST. cdr_lock low alone -> CDR_RST.
  - Entering READY clears retry_cnt.
  - FAULT: sticky while phy_en_req=1 (see Optional Feature). Leaves only via phy_en_req low -> OFF.
- Lock filter state: the filters run continuously. Reset clears them; they are not cleared on state change.

Optional Feature:
Macro SERDESPHY_SEQ_AUTO_RETRY_EN.
- Defined: FAULT holds for PLL_RST_CYCLES cycles, then goes to PLL_RST with retry_cnt incremented, while retry_cnt < MAX_RETRY. Once retry_cnt == MAX_RETRY, FAULT is sticky. retry_cnt saturates at MAX_RETRY.
- Undefined: FAULT is always sticky and retry_cnt is tied to 0.

Test Plan:
1. Nominal bring-up. Parameters PLL_RST_CYCLES=4, LOCK_FILT=2. Hold rst_in high then release with phy_en_req=1; raise pll_lock and cdr_lock while waiting. Required: pll_rst stays high exactly 4 cycles after phy_en rises; seq_state steps 1,2,3,4,5; seq_ready=1.
2. Lock glitch. In PLL_WAIT, pulse pll_lock high 1 cycle, low 1 cycle, then high steady. Required: CDR_RST is entered only after 2 consecutive high cycles.
3. PLL timeout. PLL_LOCK_TIMEOUT=20 and pll_lock held low. Required: seq_state=6, seq_fault=1, phy_en=0 at the timeout cycle, and it remains there with the macro undefined.
4. Lock loss in READY. Drop cdr_lock: required -> CDR_RST with rx_en=0 and tx_en=1. Then drop pll_lock in READY: required -> PLL_RST.
5. Abort. Deassert phy_en_req mid-CDR_WAIT: required OFF on the next edge. Assert rst_in mid-sequence: required OFF asynchronously, with the reset values listed in Behaviour.
6. With SERDESPHY_SEQ_AUTO_RETRY_EN and MAX_RETRY=2, PLL never locks. Required: retry_cnt goes 1 then 2, then FAULT is sticky. A later successful lock clears retry_cnt to 0 in READY.
